// File: rtl/oc0a_perst_pkg.sv
// Shared types for the oc0a PERST# sequencer: state encoding and the
// state-to-pin decode used for the registered PERST# output.
package oc0a_perst_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    TRAIN = 3'd2,
    UP    = 3'd3,
    FAIL  = 3'd4
  } perst_state_e;

  // PERST# is released (driven high) only while training or with the link up.
  function automatic logic perstn_of(input perst_state_e s);
    return (s == TRAIN) || (s == UP);
  endfunction

endpackage

// File: rtl/oc0a_perst_seq_sync_2ff.sv
// Two-flop synchronizer, resets to 0 so a synchronized active-low reset
// input reads as "asserted" until it has been seen high for two clocks.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values are a plain shift of the asynchronous input.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/oc0a_perst_seq.sv
// PERST# sequencer for the oc0a NVMe port. Holds the device in reset until
// host reset is released and refclk is stable, releases PERST# after a fixed
// hold, then supervises link training with a timeout and bounded retries.
//
// state | meaning
// IDLE  | PERST# asserted, waiting for host out of reset and refclk stable
// HOLD  | PERST# asserted, counting the hold time
// TRAIN | PERST# released, waiting for link_up with timeout
// UP    | link trained, link_ok high
// FAIL  | retries exhausted, PERST# asserted, sticky until sw_reset_req
module oc0a_perst_seq #(
  parameter int unsigned PERST_CYCLES = 25000000,
  parameter int unsigned LINK_TIMEOUT = 250000000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RETRY_W      = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               host_perstn,
  input  logic               refclk_stable,
  input  logic               link_up,
  input  logic               sw_reset_req,
  output logic               oc0a_perstn,
  output logic               link_ok,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  import oc0a_perst_pkg::*;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(PERST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TRAIN_LAST = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  logic hp_s;

  sync_2ff u_sync_hp (
    .clk  (clk),
    .rstn (rstn),
    .d    (host_perstn),
    .q    (hp_s)
  );

  perst_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               perstn_q, perstn_d;
  logic               link_ok_q, link_ok_d;
  logic               fail_q, fail_d;

  // State, shared counter, retry count and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      perstn_q  <= 1'b0;
      link_ok_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      perstn_q  <= perstn_d;
      link_ok_q <= link_ok_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state logic: overrides first, then the normal sequence. Every
  // terminal-count compare clears the counter, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (!hp_s || !refclk_stable || sw_reset_req) begin
      state_d = IDLE;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = HOLD;
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = TRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TRAIN: begin
          // link_up wins over a timeout on the same cycle.
          if (link_up) begin
            cnt_d   = '0;
            state_d = UP;
          end else if (cnt_q == TRAIN_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAIL;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        UP: begin
          cnt_d = '0;
          if (!link_up) begin
            retry_d = '0;
            state_d = IDLE;
          end
        end
        FAIL: begin
          cnt_d = '0;
        end
        default: begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they register with the state.
  always_comb begin
    perstn_d  = perstn_of(state_d);
    link_ok_d = (state_d == UP);
    fail_d    = (state_d == FAIL);
  end

  assign oc0a_perstn = perstn_q;
  assign link_ok     = link_ok_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_oc0a_perst_seq.sv
module tb_oc0a_perst_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       host_perstn;
  logic       refclk_stable;
  logic       link_up;
  logic       sw_reset_req;
  logic       oc0a_perstn;
  logic       link_ok;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  oc0a_perst_seq #(
    .PERST_CYCLES (8),
    .LINK_TIMEOUT (16),
    .MAX_RETRY    (2),
    .CNT_W        (8),
    .RETRY_W      (2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .host_perstn   (host_perstn),
    .refclk_stable (refclk_stable),
    .link_up       (link_up),
    .sw_reset_req  (sw_reset_req),
    .oc0a_perstn   (oc0a_perstn),
    .link_ok       (link_ok),
    .fail          (fail),
    .retry_cnt     (retry_cnt),
    .state         (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         c;
    logic [7:0] v;
  } ev_t;

  ev_t sb[$];

  // tuple = {state[2:0], oc0a_perstn, link_ok, fail, retry_cnt[1:0]}
  function automatic logic [7:0] tup(input int st, input bit pn, input bit lo,
                                     input bit fl, input int rc);
    return {st[2:0], pn, lo, fl, rc[1:0]};
  endfunction

  task automatic push(input int c, input logic [7:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int tgt);
    while (cyc < tgt) @(negedge clk);
  endtask

  // Monitor: every change of the output tuple must match the next queued event.
  logic [7:0] cur;
  logic [7:0] prev = 8'h00;
  ev_t        got;
  always @(negedge clk) begin
    cur = {state, oc0a_perstn, link_ok, fail, retry_cnt};
    while (sb.size() > 0 && sb[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event: expected %h at cycle %0d, not observed by cycle %0d",
               sb[0].v, sb[0].c, cyc);
      void'(sb.pop_front());
    end
    if (cur !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h (was %h) at cycle %0d", cur, prev, cyc);
      end else begin
        got = sb.pop_front();
        if (got.v !== cur || got.c != cyc) begin
          errors++;
          $display("FAIL transition: got %h at cycle %0d expected %h at cycle %0d",
                   cur, cyc, got.v, got.c);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  int t;
  initial begin
    rstn          = 1'b0;
    host_perstn   = 1'b0;
    refclk_stable = 1'b1;
    link_up       = 1'b0;
    sw_reset_req  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {state, oc0a_perstn, link_ok, fail, retry_cnt}, 8'h00);
    rstn = 1'b1;
    @(negedge clk);

    // Normal bring-up
    t = cyc;
    host_perstn = 1'b1;
    push(t + 3,  tup(1, 0, 0, 0, 0));
    push(t + 11, tup(2, 1, 0, 0, 0));
    wait_to(t + 15);
    link_up = 1'b1;
    push(t + 16, tup(3, 1, 1, 0, 0));
    wait_to(t + 20);

    // Host reset while UP
    t = cyc;
    host_perstn = 1'b0;
    push(t + 3, tup(0, 0, 0, 0, 0));
    wait_to(t + 6);
    link_up = 1'b0;

    // Retries to FAIL
    t = cyc;
    host_perstn = 1'b1;
    push(t + 3,  tup(1, 0, 0, 0, 0));
    push(t + 11, tup(2, 1, 0, 0, 0));
    push(t + 27, tup(1, 0, 0, 0, 1));
    push(t + 35, tup(2, 1, 0, 0, 1));
    push(t + 51, tup(1, 0, 0, 0, 2));
    push(t + 59, tup(2, 1, 0, 0, 2));
    push(t + 75, tup(4, 0, 0, 1, 2));
    wait_to(t + 175);
    chk("fail_sticky", {state, oc0a_perstn, link_ok, fail, retry_cnt}, tup(4, 0, 0, 1, 2));

    // sw_reset_req clears FAIL; then one timeout and a link_up on the last TRAIN cycle
    t = cyc;
    sw_reset_req = 1'b1;
    push(t + 1,  tup(0, 0, 0, 0, 0));
    push(t + 2,  tup(1, 0, 0, 0, 0));
    push(t + 10, tup(2, 1, 0, 0, 0));
    push(t + 26, tup(1, 0, 0, 0, 1));
    push(t + 34, tup(2, 1, 0, 0, 1));
    @(negedge clk);
    sw_reset_req = 1'b0;
    wait_to(t + 49);
    link_up = 1'b1;
    push(t + 50, tup(3, 1, 1, 0, 1));
    wait_to(t + 54);

    // Link drop from UP, then refclk loss during HOLD at count 4
    t = cyc;
    link_up = 1'b0;
    push(t + 1, tup(0, 0, 0, 0, 0));
    push(t + 2, tup(1, 0, 0, 0, 0));
    wait_to(t + 6);
    refclk_stable = 1'b0;
    push(t + 7, tup(0, 0, 0, 0, 0));
    @(negedge clk);
    refclk_stable = 1'b1;
    push(t + 8,  tup(1, 0, 0, 0, 0));
    push(t + 16, tup(2, 1, 0, 0, 0));
    wait_to(t + 20);

    // Async reset mid-TRAIN, away from clock edges
    #2;
    rstn = 1'b0;
    push(cyc + 1, tup(0, 0, 0, 0, 0));
    #1;
    chk("async_reset", {state, oc0a_perstn, link_ok, fail, retry_cnt}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    t = cyc;
    push(t + 3, tup(1, 0, 0, 0, 0));
    wait_to(t + 6);

    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oc0a_perst_seq.md
# oc0a_perst_seq

PERST# sequencer for the oc0a NVMe device port. Sits between the host-side reset/clock status and the `oc0a_perstn` board pin. It holds the downstream device in reset until the host is out of reset and the reference clock is stable, then releases PERST# after a fixed hold time. It supervises link training with a timeout and bounded retries, and reports link/fail status to the rest of `design_1`.

## Interface
Parameters:
- PERST_CYCLES, 25000000 — cycles PERST# stays asserted before release (100 ms at 250 MHz); must be ≥ 2
- LINK_TIMEOUT, 250000000 — cycles allowed in TRAIN for `link_up`; must be ≥ 2
- MAX_RETRY, 3 — retrain attempts after the first timeout before FAIL
- CNT_W, 32 — width of the shared hold/timeout counter; must hold max(PERST_CYCLES, LINK_TIMEOUT)
- RETRY_W, 2 — width of `retry_cnt`; must hold MAX_RETRY

Ports:
- clk  in  1  free-running system clock; all logic in this domain
- rstn  in  1  asynchronous, active-low reset
- host_perstn  in  1  host PERST#, asynchronous, active-low; synchronized internally
- refclk_stable  in  1  oc0a reference clock locked (clk domain)
- link_up  in  1  device-side PCIe link-up (clk domain)
- sw_reset_req  in  1  single-cycle pulse; re-arms the sequence and clears FAIL
- oc0a_perstn  out  1  registered PERST# to the device, active-low
- link_ok  out  1  high only in state UP
- fail  out  1  high only in state FAIL
- retry_cnt  out  RETRY_W  timeouts taken in the current sequence
- state  out  3  current state encoding, for debug

## Operation
- `host_perstn` passes through a 2-flop synchronizer, producing `hp_s`.
- States:
  - IDLE=0: PERST# asserted, counter cleared. Go to HOLD when `hp_s` and `refclk_stable` are both 1.
  - HOLD=1: PERST# asserted. Counter increments each cycle. At count == PERST_CYCLES-1, clear the counter and go to TRAIN.
  - TRAIN=2: PERST# deasserted. Counter increments each cycle.
    - If `link_up` is 1, go to UP.
    - Otherwise, at count == LINK_TIMEOUT-1:
      - if `retry_cnt` == MAX_RETRY, go to FAIL;
      - else increment `retry_cnt` and go to HOLD with the counter cleared.
  - UP=3: PERST# deasserted, `link_ok`=1. If `link_up` drops to 0, go to IDLE and clear `retry_cnt`.
  - FAIL=4: PERST# asserted, `fail`=1. Sticky. Exits only via `sw_reset_req` or reset.
- Override priority, evaluated every cycle in every state, highest first:
  1. `hp_s`=0 → IDLE; clear counter and `retry_cnt`. FAIL is also cleared.
  2. `refclk_stable`=0 → IDLE; same clears; FAIL is also cleared.
  3. `sw_reset_req`=1 → IDLE; clear counter, `retry_cnt` and FAIL.
  4. Normal transitions above.
- Same cycle as a TRAIN timeout, `link_up`=1 wins and the next state is UP.
- `sw_reset_req` asserted while already in IDLE has no effect beyond the clears.
- Counter arithmetic is unsigned, CNT_W bits. It never wraps, because every compare triggers a clear first.

## Timing
- Reset values: `state`=IDLE, `oc0a_perstn`=0, `link_ok`=0, `fail`=0, `retry_cnt`=0, counter=0.
- `oc0a_perstn`, `link_ok` and `fail` are registered, decoded from the next state. They change on the same edge as `state` and never glitch.
- `host_perstn` rising edge to leaving IDLE: 3 clk edges (2 sync + 1 FSM), given `refclk_stable`=1.
- `host_perstn` falling edge to `oc0a_perstn`=0: at most 3 clk edges.
- HOLD entry edge to `oc0a_perstn` rising: exactly PERST_CYCLES edges.
- `link_up` sampled high in TRAIN → `link_ok`=1 on the next edge.
- Timeout: TRAIN entry to HOLD/FAIL entry is exactly LINK_TIMEOUT edges.
- Async reset mid-sequence forces all reset values immediately. PERST# asserts with no clock required.

## Structure
- Package `oc0a_perst_pkg`: `perst_state_e` enum (3-bit, values above) and the state-decode helper for `oc0a_perstn`.
- Sub-module `sync_2ff` (1-bit, async active-low reset to 0) for `host_perstn`. Resetting to 0 keeps PERST# asserted through reset exit.
- Remainder is one FSM plus one shared counter in `oc0a_perst_seq`.

## Test plan
All scenarios use PERST_CYCLES=8, LINK_TIMEOUT=16, MAX_RETRY=2.
- Normal bring-up: `refclk_stable`=1; raise `host_perstn`; raise `link_up` 5 cycles after `oc0a_perstn` rises → HOLD entered 3 edges after `host_perstn`; `oc0a_perstn` rises 8 edges later; `link_ok`=1 one edge after `link_up`; `retry_cnt`=0.
- Retry to fail: `link_up` held at 0 → 3 TRAIN windows of 16 cycles each, `retry_cnt` going 0→1→2; then FAIL with `fail`=1 and `oc0a_perstn`=0. Hold `sw_reset_req`=0 for 100 cycles → still FAIL. Pulse `sw_reset_req` → IDLE, then HOLD.
- Boundary: `link_up` asserted exactly on the 16th TRAIN cycle → UP, `retry_cnt` unchanged.
- Host reset mid-UP: drop `host_perstn` → `oc0a_perstn`=0 within 3 edges, `link_ok`=0, `retry_cnt`=0.
- Refclk loss during HOLD at count 4 → IDLE. On return, the full 8-cycle hold restarts.
- Async `rstn` pulse mid-TRAIN, away from clock edges → all outputs at reset values immediately.
